// File: rtl/exec_stage.sv
// Execute/writeback stage for a threadbrain core.
// Takes the instruction and operand picked by the register-select stage,
// computes PLUS/MINUS results, writes them back into the shared register
// file (clearing the lock), resolves BRZ into a one-cycle squash pulse, and
// owns the data pointer that select uses to address the register file.

package exec_stage_pkg;
    localparam int ENTRY_W = 35;

    localparam logic [3:0] OP_PLUS  = 4'd1;
    localparam logic [3:0] OP_MINUS = 4'd2;
    localparam logic [3:0] OP_RIGHT = 4'd3;
    localparam logic [3:0] OP_LEFT  = 4'd4;
    localparam logic [3:0] OP_BRZ   = 4'd5;

    // One register-file entry, MSB first: {valid, retr, locked, tag, val}.
    typedef struct packed {
        logic        valid;
        logic        retr;
        logic        locked;
        logic [15:0] tag;
        logic [15:0] val;
    } rf_entry_t;

    // Contents of the EX register captured at accept time.
    typedef struct packed {
        logic [15:0] ins;
        logic [15:0] val;
        logic [15:0] ptr;
        logic [15:0] pc;
    } ex_req_t;
endpackage

// Per-entry writeback lane. Lanes are chained from index 0 upwards through
// claimed_in/claimed_out so only the lowest matching entry gets written.
module exec_rf_lane
    import exec_stage_pkg::*;
(
    input  logic [ENTRY_W-1:0] entry_in,
    input  logic               wb_en,
    input  logic [15:0]        wb_tag,
    input  logic [15:0]        wb_val,
    input  logic               claimed_in,
    output logic               claimed_out,
    output logic [ENTRY_W-1:0] entry_out
);
    rf_entry_t ent;
    rf_entry_t upd;
    logic      hit;

    // Match against the writeback tag; write only if no lower lane claimed it.
    always_comb begin
        ent = rf_entry_t'(entry_in);
        upd = ent;
        hit = wb_en && ent.valid && ent.locked && (ent.tag == wb_tag);
        if (hit && !claimed_in) begin
            upd.val    = wb_val;
            upd.locked = 1'b0;
        end
        claimed_out = claimed_in || hit;
        entry_out   = upd;
    end
endmodule

module exec_stage
    import exec_stage_pkg::*;
#(
    parameter int NCORES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               ins_in,
    input  logic [15:0]               val_in,
    input  logic [15:0]               pc_in,
    input  logic                      stall_in,
    input  logic [NCORES*ENTRY_W-1:0] rf_in,
    output logic [NCORES*ENTRY_W-1:0] rf_out,
    output logic [15:0]               ptr,
    output logic                      branch_en,
    output logic [15:0]               branch_target,
    output logic [15:0]               retired,
    output logic                      wb_miss
);
    localparam int STAGES = 1;

    // vld_pipe[0]: instruction accepted this cycle, vld_pipe[STAGES]: EX valid.
    logic [STAGES:0] vld_pipe;
    logic            accept;
    logic            ex_valid;
    ex_req_t         ex;

    logic [3:0]      in_op;
    logic [3:0]      ex_op;
    logic [15:0]     result;
    logic            wb_en;
    logic            wb_miss_now;
    logic            brz_taken;
    logic [NCORES:0] claim;

    assign in_op    = ins_in[15:12];
    assign ex_op    = ex.ins[15:12];

    // A squash pulse or an upstream stall both mean nothing valid is offered.
    assign accept   = !stall_in && !branch_en;
    assign vld_pipe = {ex_valid, accept};

    // PLUS/MINUS result, 16-bit wrap.
    always_comb begin
        result = ex.val + 16'd1;
        if (ex_op == OP_MINUS) begin
            result = ex.val - 16'd1;
        end
    end

    // Writeback is suppressed while rst is high so a reset edge never commits
    // an abandoned instruction into the register file.
    assign wb_en       = vld_pipe[STAGES] && !rst &&
                         ((ex_op == OP_PLUS) || (ex_op == OP_MINUS));
    assign wb_miss_now = wb_en && !claim[NCORES];
    assign brz_taken   = vld_pipe[STAGES] && (ex_op == OP_BRZ) && (ex.val == 16'd0);

    assign claim[0] = 1'b0;

    for (genvar i = 0; i < NCORES; i++) begin : g_lane
        exec_rf_lane u_lane (
            .entry_in    (rf_in[i*ENTRY_W +: ENTRY_W]),
            .wb_en       (wb_en),
            .wb_tag      (ex.ptr),
            .wb_val      (result),
            .claimed_in  (claim[i]),
            .claimed_out (claim[i+1]),
            .entry_out   (rf_out[i*ENTRY_W +: ENTRY_W])
        );
    end

    // EX register: capture the offered instruction on accept, else go idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex       <= '0;
        end else begin
            ex_valid <= vld_pipe[0];
            if (vld_pipe[0]) begin
                ex.ins <= ins_in;
                ex.val <= val_in;
                ex.ptr <= ptr;
                ex.pc  <= pc_in;
            end
        end
    end

    // Data pointer moves as soon as RIGHT/LEFT is accepted, so the next
    // instruction already selects with the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 16'd0;
        end else if (vld_pipe[0]) begin
            if (in_op == OP_RIGHT) begin
                ptr <= ptr + 16'd1;
            end else if (in_op == OP_LEFT) begin
                ptr <= ptr - 16'd1;
            end
        end
    end

    // Taken BRZ becomes a single-cycle pulse; the target holds afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_en     <= 1'b0;
            branch_target <= 16'd0;
        end else begin
            branch_en <= brz_taken;
            if (brz_taken) begin
                branch_target <= {4'h0, ex.ins[11:0]};
            end
        end
    end

    // Retire counter (saturating) and sticky writeback-miss flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= 16'd0;
            wb_miss <= 1'b0;
        end else begin
            if (vld_pipe[STAGES] && (retired != 16'hFFFF)) begin
                retired <= retired + 16'd1;
            end
            if (wb_miss_now) begin
                wb_miss <= 1'b1;
            end
        end
    end

    // The captured pc is kept only for debug visibility in waveforms.
    logic unused_dbg;
    assign unused_dbg = ^ex.pc;
endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: a driver issues one cycle of stimulus at a
// time and a reference model pushes the outputs expected for that cycle; a
// monitor on the falling edge pops and compares.
module tb_exec_stage;
    localparam int N   = 4;
    localparam int EW  = 35;
    localparam int RFW = N * EW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [15:0]    ins_in = '0;
    logic [15:0]    val_in = '0;
    logic [15:0]    pc_in = '0;
    logic           stall_in = 1'b0;
    logic [RFW-1:0] rf_in = '0;
    logic [RFW-1:0] rf_out;
    logic [15:0]    ptr;
    logic           branch_en;
    logic [15:0]    branch_target;
    logic [15:0]    retired;
    logic           wb_miss;

    always #5 clk = ~clk;

    exec_stage #(.NCORES(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .ins_in        (ins_in),
        .val_in        (val_in),
        .pc_in         (pc_in),
        .stall_in      (stall_in),
        .rf_in         (rf_in),
        .rf_out        (rf_out),
        .ptr           (ptr),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .retired       (retired),
        .wb_miss       (wb_miss)
    );

    typedef struct {
        logic [RFW-1:0] rf;
        logic [15:0]    ptr;
        logic           ben;
        logic [15:0]    tgt;
        logic [15:0]    ret;
        logic           miss;
        int             cyc;
    } exp_t;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] val;
        logic [15:0] ptr;
    } pend_t;

    exp_t  exp_q[$];
    pend_t ex_q[$];   // instruction sitting in execute (0 or 1 entries)

    logic [15:0] m_ptr = '0, m_tgt = '0, m_ret = '0;
    logic        m_ben = 1'b0, m_miss = 1'b0;
    bit          m_known = 0;
    int          checks = 0, errors = 0, cycn = 0;

    function automatic logic [EW-1:0] mk(input logic v, input logic r, input logic l,
                                         input logic [15:0] tag, input logic [15:0] val);
        mk = {v, r, l, tag, val};
    endfunction

    function automatic logic [15:0] cur_exptr();
        logic [15:0] t;
        t = 16'($urandom);
        if (ex_q.size() != 0) t = ex_q[0].ptr;
        return t;
    endfunction

    // Register file with nothing locked: no writeback can hit it.
    function automatic logic [RFW-1:0] rf_bg();
        logic [RFW-1:0] rf;
        for (int i = 0; i < N; i++)
            rf[i*EW +: EW] = mk(1'b1, 1'($urandom), 1'b0, 16'($urandom), 16'($urandom));
        return rf;
    endfunction

    // Random register file biased toward entries that match the pending tag.
    function automatic logic [RFW-1:0] rand_rf();
        logic [RFW-1:0] rf;
        logic [15:0]    t;
        t = cur_exptr();
        for (int i = 0; i < N; i++)
            rf[i*EW +: EW] = mk(1'($urandom), 1'($urandom), 1'($urandom),
                                ($urandom_range(0, 1) == 1) ? t : 16'($urandom),
                                16'($urandom));
        return rf;
    endfunction

    // Reference model: expected outputs for the cycle now being driven, then
    // the architectural effect of the coming clock edge.
    task automatic model_step(input logic [15:0] ins, input logic [15:0] val,
                              input logic stall, input logic [RFW-1:0] rf, input logic r);
        exp_t           e;
        pend_t          p;
        logic [RFW-1:0] o;
        logic [EW-1:0]  en;
        logic [15:0]    res;
        logic [3:0]     op;
        bit             found;
        bit             nben;
        found = 0;
        nben  = 0;
        o     = rf;
        if (!r && ex_q.size() != 0) begin
            p  = ex_q[0];
            op = p.ins[15:12];
            if (op == 4'd1 || op == 4'd2) begin
                res = (op == 4'd1) ? p.val + 16'd1 : p.val - 16'd1;
                for (int i = 0; i < N; i++) begin
                    en = rf[i*EW +: EW];
                    if (!found && en[34] && en[32] && en[31:16] == p.ptr) begin
                        found      = 1;
                        en[32]     = 1'b0;
                        en[15:0]   = res;
                        o[i*EW +: EW] = en;
                    end
                end
            end
        end
        if (m_known) begin
            e.rf = o; e.ptr = m_ptr; e.ben = m_ben; e.tgt = m_tgt;
            e.ret = m_ret; e.miss = m_miss; e.cyc = cycn;
            exp_q.push_back(e);
        end
        if (r) begin
            m_ptr = '0; m_ben = 0; m_tgt = '0; m_ret = '0; m_miss = 0;
            ex_q.delete();
            m_known = 1;
        end else if (m_known) begin
            if (ex_q.size() != 0) begin
                p  = ex_q.pop_front();
                op = p.ins[15:12];
                if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
                if ((op == 4'd1 || op == 4'd2) && !found) m_miss = 1;
                if (op == 4'd5 && p.val == 16'd0) begin
                    nben  = 1;
                    m_tgt = {4'h0, p.ins[11:0]};
                end
            end
            if (!stall && !m_ben) begin
                ex_q.push_back('{ins, val, m_ptr});
                if (ins[15:12] == 4'd3) m_ptr = m_ptr + 16'd1;
                else if (ins[15:12] == 4'd4) m_ptr = m_ptr - 16'd1;
            end
            m_ben = nben;
        end
    endtask

    task automatic cyc(input logic [15:0] ins, input logic [15:0] val, input logic stall,
                       input logic [RFW-1:0] rf, input logic r);
        @(posedge clk);
        #1;
        cycn++;
        rst = r; ins_in = ins; val_in = val; stall_in = stall; rf_in = rf;
        pc_in = 16'($urandom);
        model_step(ins, val, stall, rf, r);
    endtask

    task automatic check(input string nm, input logic [RFW-1:0] got,
                         input logic [RFW-1:0] want, input int c);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, want);
        end
    endtask

    // Monitor: the DUT presents a full set of outputs every cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rf_out", rf_out, e.rf, e.cyc);
            check("ptr", RFW'(ptr), RFW'(e.ptr), e.cyc);
            check("branch_en", RFW'(branch_en), RFW'(e.ben), e.cyc);
            check("branch_target", RFW'(branch_target), RFW'(e.tgt), e.cyc);
            check("retired", RFW'(retired), RFW'(e.ret), e.cyc);
            check("wb_miss", RFW'(wb_miss), RFW'(e.miss), e.cyc);
        end
    end

    initial begin
        logic [RFW-1:0] rf;
        logic [15:0]    ins, v;
        logic [3:0]     ops [10];
        ops = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd0, 4'd7};

        cyc(16'h0000, 16'h0, 0, '0, 1);
        cyc(16'h0000, 16'h0, 0, '0, 1);

        // PLUS at ptr 0, val 7 -> entry 2 written with 8, unlocked
        cyc(16'h1000, 16'h0007, 0, '0, 0);
        rf = rf_bg(); rf[2*EW +: EW] = mk(1, 0, 1, 16'h0000, 16'h0007);
        cyc(16'h0000, 16'h0, 0, rf, 0);

        // MINUS of 0 wraps to FFFF; PLUS of FFFF wraps to 0
        cyc(16'h2000, 16'h0000, 0, rf_bg(), 0);
        rf = rf_bg(); rf[1*EW +: EW] = mk(1, 1, 1, 16'h0000, 16'h1234);
        cyc(16'h1000, 16'hFFFF, 0, rf, 0);
        rf = rf_bg(); rf[0*EW +: EW] = mk(1, 0, 1, 16'h0000, 16'h0042);
        cyc(16'h0000, 16'h0, 0, rf, 0);

        // LEFT at 0, RIGHT twice, stalled RIGHT
        cyc(16'h4000, 16'h0, 0, rf_bg(), 0);
        cyc(16'h3000, 16'h0, 0, rf_bg(), 0);
        cyc(16'h3000, 16'h0, 0, rf_bg(), 0);
        cyc(16'h3000, 16'h0, 1, rf_bg(), 0);
        cyc(16'h0000, 16'h0, 0, rf_bg(), 0);

        // Taken BRZ, RIGHT presented during the pulse is dropped
        cyc(16'h5123, 16'h0000, 0, rf_bg(), 0);
        cyc(16'h0000, 16'h0, 0, rf_bg(), 0);
        cyc(16'h3000, 16'h0, 0, rf_bg(), 0);
        cyc(16'h0000, 16'h0, 0, rf_bg(), 0);
        // Not-taken BRZ
        cyc(16'h5123, 16'h0003, 0, rf_bg(), 0);
        cyc(16'h0000, 16'h0, 0, rf_bg(), 0);
        cyc(16'h0000, 16'h0, 0, rf_bg(), 0);

        // Writeback miss, then sticky
        cyc(16'h1000, 16'h0005, 0, rf_bg(), 0);
        cyc(16'h0000, 16'h0, 0, rf_bg(), 0);
        cyc(16'h0000, 16'h0, 0, rf_bg(), 0);
        cyc(16'h0000, 16'h0, 0, rf_bg(), 0);

        // Two matching locked entries: only index 1 written
        cyc(16'h1000, 16'h0009, 0, rf_bg(), 0);
        rf = rf_bg();
        rf[1*EW +: EW] = mk(1, 0, 1, cur_exptr(), 16'h1111);
        rf[3*EW +: EW] = mk(1, 1, 1, cur_exptr(), 16'h3333);
        cyc(16'h0000, 16'h0, 0, rf, 0);

        // Reset the cycle after a PLUS is accepted: no writeback
        cyc(16'h3000, 16'h0, 0, rf_bg(), 0);
        cyc(16'h1000, 16'h0004, 0, rf_bg(), 0);
        rf = rf_bg(); rf[0*EW +: EW] = mk(1, 0, 1, cur_exptr(), 16'h0004);
        cyc(16'h0000, 16'h0, 0, rf, 1);
        cyc(16'h0000, 16'h0, 0, rf_bg(), 0);
        cyc(16'h0000, 16'h0, 0, rf_bg(), 0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            ins = {ops[$urandom_range(0, 9)], 12'($urandom)};
            case ($urandom_range(0, 3))
                0, 1:    v = 16'h0000;
                2:       v = 16'hFFFF;
                default: v = 16'($urandom);
            endcase
            cyc(ins, v, ($urandom_range(0, 4) == 0), rand_rf(), ($urandom_range(0, 99) == 0));
        end

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
